// File: rtl/tone_synth.sv
// Note-to-tone synthesiser: one-deep note slot, preset decode, square-wave divider.
// Optional octave transpose is enabled by defining TONE_SYNTH_OCT_EN.
module tone_synth #(
  parameter int TW = 11
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          TICK_EN,
  input  logic          NOTE_VALID,
  input  logic [3:0]    NOTE_IDX,
  output logic          NOTE_READY,
  input  logic [1:0]    OCT,
  output logic [3:0]    CODE,
  output logic          H,
  output logic [TW-1:0] TO,
  output logic          SPKS,
  output logic          BUSY
);

  typedef enum logic {
    S_IDLE,
    S_PLAY
  } state_t;

  state_t state;
  state_t state_nx;

  logic          pend_valid;
  logic [3:0]    pend_idx;
  logic          pend_rest;
  logic          pend_hi;
  logic          accept;
  logic          ovf;
  logic          consume;

  logic [TW-1:0] cnt;

  logic [10:0]   base;
  logic [3:0]    dec_code;
  logic          dec_h;
  logic [TW-1:0] dec_to;
  logic [TW-1:0] btw;
  logic [TW-1:0] span;
  logic [TW-1:0] half;
  logic [TW-1:0] tone_to;

  assign accept    = NOTE_VALID && !pend_valid;
  assign ovf       = TICK_EN && (&cnt);
  assign pend_rest = (pend_idx == 4'd0) || (pend_idx == 4'd15);
  assign pend_hi   = !pend_rest && (pend_idx >= 4'd8);
  assign consume   = pend_valid && ((state == S_IDLE) || ovf);

  // Base preset table at TW = 11; rests map to zero.
  always_comb begin
    base = 11'd0;
    case (pend_idx)
      4'd1:    base = 11'd773;
      4'd2:    base = 11'd912;
      4'd3:    base = 11'd1036;
      4'd4:    base = 11'd1116;
      4'd5:    base = 11'd1197;
      4'd6:    base = 11'd1290;
      4'd7:    base = 11'd1372;
      4'd8:    base = 11'd1410;
      4'd9:    base = 11'd1480;
      4'd10:   base = 11'd1542;
      4'd11:   base = 11'd1622;
      4'd12:   base = 11'd1668;
      4'd13:   base = 11'd1728;
      4'd14:   base = 11'd1770;
      default: base = 11'd0;
    endcase
  end

  // Half-period and preset, done modulo 2^TW:
  // 2^TW - x equals -x in TW bits.
  assign btw  = TW'(base) << (TW - 11);
  assign span = TW'(0) - btw;

`ifdef TONE_SYNTH_OCT_EN
  assign half = span >> OCT;
`else
  logic [1:0] oct_unused;
  assign oct_unused = OCT;
  assign half = span;
`endif

  assign tone_to = TW'(0) - half;

  // Note name, octave flag and preset of the pending note.
  always_comb begin
    dec_code = 4'd0;
    dec_h    = 1'b0;
    dec_to   = '1;
    unique case (1'b1)
      pend_rest: begin
        dec_code = 4'd0;
        dec_h    = 1'b0;
        dec_to   = '1;
      end
      pend_hi: begin
        dec_code = pend_idx - 4'd7;
        dec_h    = 1'b1;
        dec_to   = tone_to;
      end
      default: begin
        dec_code = pend_idx;
        dec_h    = 1'b0;
        dec_to   = tone_to;
      end
    endcase
  end

  // One-deep pending slot; accept and consume never coincide.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_valid <= 1'b0;
      pend_idx   <= 4'd0;
    end else if (consume) begin
      pend_valid <= 1'b0;
    end else if (accept) begin
      pend_valid <= 1'b1;
      pend_idx   <= NOTE_IDX;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state: tones start play, rests stop it at a boundary.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (pend_valid && !pend_rest) begin
          state_nx = S_PLAY;
        end
      end
      S_PLAY: begin
        if (ovf && pend_valid && pend_rest) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Handshake and activity flags.
  always_comb begin
    NOTE_READY = !pend_valid;
    BUSY       = (state == S_PLAY);
  end

  // Divider, speaker level and active-note registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt  <= '1;
      SPKS <= 1'b0;
      CODE <= 4'd0;
      H    <= 1'b0;
      TO   <= '1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pend_valid) begin
            CODE <= dec_code;
            H    <= dec_h;
            TO   <= dec_to;
            SPKS <= 1'b0;
            if (!pend_rest) begin
              cnt <= dec_to;
            end
          end
        end
        S_PLAY: begin
          if (ovf) begin
            if (pend_valid && pend_rest) begin
              SPKS <= 1'b0;
              CODE <= dec_code;
              H    <= dec_h;
              TO   <= dec_to;
            end else if (pend_valid) begin
              SPKS <= ~SPKS;
              cnt  <= dec_to;
              CODE <= dec_code;
              H    <= dec_h;
              TO   <= dec_to;
            end else begin
              SPKS <= ~SPKS;
              cnt  <= TO;
            end
          end else if (TICK_EN) begin
            cnt <= cnt + TW'(1);
          end
        end
        default: begin
          SPKS <= 1'b0;
        end
      endcase
    end
  end

endmodule
